dmem_ctrl: RTL and testbench

Parametrised data-memory block for the EC413 processor datapath: byte-addressed word storage behind a valid/ready request port, with byte/half/word stores and loads, sign or zero extension, misalignment detection and a configurable number of wait states that model a slow memory. It replaces the single-port data memory on the datapath's load/store path. The pipeline stalls while `ReqReady` is low and takes load data on `RespValid`.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 18 +
 rtl/dmem_ctrl.sv | 102 ++++++++++
 tb/tb_dmem_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and byte-lane decode for dmem_ctrl
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] be;
    } lane_t;

    // An erroneous request enables no lanes, so callers can gate writes on be alone
    function automatic lane_t lane_sel(input logic [1:0] size, input logic [1:0] a);
        lane_t l;
        l.err = (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00) || size == 2'b11;
        l.be  = l.err ? 4'b0000 :
                size == SZ_BYTE ? 4'b0001 << a :
                size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        return l;
    endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 32-bit word storage with byte write enables and asynchronous read
module dmem_array #(
    parameter int WORD_ADDR_WIDTH = 14
) (
    input  logic                       clk,
    input  logic [3:0]                 we,
    input  logic [WORD_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);
    logic [31:0] mem [2**WORD_ADDR_WIDTH];

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: valid/ready data memory with byte/half/word access, extension and wait states
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [1:0]            ReqSize,
    input  logic                  ReqSigned,
    input  logic [31:0]           ReqWData,
    output logic                  RespValid,
    output logic [31:0]           RespRData,
    output logic                  RespError
);
    localparam logic       NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_write, lat_signed;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_size;
    logic [31:0]           lat_wdata;

    logic                  in_idle, accept, commit;
    logic                  cur_write, cur_signed;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_size;
    logic [31:0]           cur_wdata, wlane, rword, load_v;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    lane_t                 lane;

    assign in_idle  = state == S_IDLE;
    assign ReqReady = in_idle && !Rst;
    assign accept   = ReqValid && ReqReady;
    // With no wait states the commit edge is the acceptance edge, so steer from the live request
    assign cur_write  = in_idle ? ReqWrite  : lat_write;
    assign cur_signed = in_idle ? ReqSigned : lat_signed;
    assign cur_addr   = in_idle ? ReqAddr   : lat_addr;
    assign cur_size   = in_idle ? ReqSize   : lat_size;
    assign cur_wdata  = in_idle ? ReqWData  : lat_wdata;
    assign commit     = (state == S_WAIT && cnt == 4'd0) || (accept && NO_WAIT);
    assign lane       = lane_sel(cur_size, cur_addr[1:0]);

    always_comb begin
        wlane  = cur_size == SZ_BYTE ? {4{cur_wdata[7:0]}} :
                 cur_size == SZ_HALF ? {2{cur_wdata[15:0]}} : cur_wdata;
        byte_v = rword[{cur_addr[1:0], 3'b000} +: 8];
        half_v = rword[{cur_addr[1], 4'b0000} +: 16];
        load_v = cur_size == SZ_BYTE ? {{24{cur_signed && byte_v[7]}}, byte_v} :
                 cur_size == SZ_HALF ? {{16{cur_signed && half_v[15]}}, half_v} : rword;
    end

    dmem_array #(.WORD_ADDR_WIDTH(ADDR_WIDTH - 2)) u_array (
        .clk   (Clk),
        .we    ((commit && cur_write) ? lane.be : 4'b0000),
        .addr  (cur_addr[ADDR_WIDTH-1:2]),
        .wdata (wlane),
        .rdata (rword)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= SZ_BYTE;
            lat_wdata  <= 32'd0;
            RespValid  <= 1'b0;
            RespError  <= 1'b0;
            RespRData  <= 32'd0;
        end else begin
            RespValid <= commit;
            if (commit) begin
                RespError <= lane.err;
                RespRData <= (!cur_write && !lane.err) ? load_v : 32'd0;
            end
            case (state)
                S_IDLE: if (accept) begin
                    lat_write  <= ReqWrite;
                    lat_signed <= ReqSigned;
                    lat_addr   <= ReqAddr;
                    lat_size   <= ReqSize;
                    lat_wdata  <= ReqWData;
                    cnt        <= CNT_INIT;
                    state      <= NO_WAIT ? S_RESP : S_WAIT;
                end
                S_WAIT: if (cnt == 4'd0) state <= S_RESP; else cnt <= cnt - 4'd1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with WAIT_STATES=2 and WAIT_STATES=0
module tb_dmem_ctrl;
    logic        Clk = 1'b0, Rst = 1'b1;
    logic        ReqValid = 1'b0, ReqValid0 = 1'b0;
    logic        ReqWrite = 1'b0, ReqSigned = 1'b0;
    logic [15:0] ReqAddr = 16'd0;
    logic [1:0]  ReqSize = 2'b10;
    logic [31:0] ReqWData = 32'd0;
    logic        rdy, rv, re, rdy0, rv0, re0;
    logic [31:0] rd, rd0;
    int          checks = 0, failures = 0;

    always #5 Clk = ~Clk;

    dmem_ctrl #(.ADDR_WIDTH(16), .WAIT_STATES(2)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(rdy), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqWData(ReqWData),
        .RespValid(rv), .RespRData(rd), .RespError(re)
    );

    dmem_ctrl #(.ADDR_WIDTH(16), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid0), .ReqReady(rdy0), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqWData(ReqWData),
        .RespValid(rv0), .RespRData(rd0), .RespError(re0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, return response data/error and edges from acceptance to response
    task automatic req(input bit sel, input bit w, input logic [15:0] a, input logic [1:0] sz,
                       input bit sg, input logic [31:0] d,
                       output logic [31:0] rdata, output logic err, output int lat);
        int n = 0;
        ReqWrite = w; ReqAddr = a; ReqSize = sz; ReqSigned = sg; ReqWData = d;
        if (sel) ReqValid0 = 1'b1; else ReqValid = 1'b1;
        while (!(sel ? rdy0 : rdy) && n < 20) begin @(posedge Clk); #1; n++; end
        @(posedge Clk); #1;
        ReqValid = 1'b0; ReqValid0 = 1'b0;
        ReqWrite = $urandom_range(0, 1); ReqAddr = 16'($urandom); ReqSize = 2'($urandom);
        ReqWData = $urandom;
        lat = 1;
        while (!(sel ? rv0 : rv) && lat < 20) begin @(posedge Clk); #1; lat++; end
        rdata = sel ? rd0 : rd;
        err = sel ? re0 : re;
        @(posedge Clk); #1;
    endtask

    task automatic run(input string tag, input bit sel, input bit w, input logic [15:0] a,
                       input logic [1:0] sz, input bit sg, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] r;
        logic        e;
        int          lat;
        req(sel, w, a, sz, sg, d, r, e, lat);
        chk({tag, ".data"}, r, exp_rd);
        chk({tag, ".err"}, {31'd0, e}, {31'd0, exp_er});
        chk({tag, ".lat"}, lat, sel ? 32'd1 : 32'd3);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.ready", {31'd0, rdy}, 32'd0);
        chk("rst.valid", {31'd0, rv}, 32'd0);
        chk("rst.err", {31'd0, re}, 32'd0);
        chk("rst.rdata", rd, 32'd0);
        Rst = 1'b0;
        #1 chk("rst.ready_after", {31'd0, rdy}, 32'd1);
        @(posedge Clk); #1;

        run("st_word", 0, 1, 16'h0010, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
        run("ld_word", 0, 0, 16'h0010, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
        run("st_word2", 0, 1, 16'h0010, 2'b10, 0, 32'h11223344, 32'h0, 0);
        run("st_byte", 0, 1, 16'h0013, 2'b00, 0, 32'hFFFFFF80, 32'h0, 0);
        run("ld_word_b", 0, 0, 16'h0010, 2'b10, 0, 32'h0, 32'h80223344, 0);
        run("ld_byte_s", 0, 0, 16'h0013, 2'b00, 1, 32'h0, 32'hFFFFFF80, 0);
        run("ld_byte_u", 0, 0, 16'h0013, 2'b00, 0, 32'h0, 32'h00000080, 0);
        run("ld_byte_l1", 0, 0, 16'h0011, 2'b00, 1, 32'h0, 32'h00000033, 0);
        run("st_half", 0, 1, 16'h0022, 2'b01, 0, 32'h0000BEEF, 32'h0, 0);
        run("ld_half_s", 0, 0, 16'h0022, 2'b01, 1, 32'h0, 32'hFFFFBEEF, 0);
        run("ld_half_u", 0, 0, 16'h0022, 2'b01, 0, 32'h0, 32'h0000BEEF, 0);
        run("ld_byte_h", 0, 0, 16'h0023, 2'b00, 0, 32'h0, 32'h000000BE, 0);

        run("st_w30", 0, 1, 16'h0030, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0);
        run("mis_st", 0, 1, 16'h0031, 2'b10, 0, 32'h55555555, 32'h0, 1);
        run("mis_hst", 0, 1, 16'h0033, 2'b01, 0, 32'h00007777, 32'h0, 1);
        run("mis_ld", 0, 0, 16'h0005, 2'b01, 1, 32'h0, 32'h0, 1);
        run("ill_ld", 0, 0, 16'h0030, 2'b11, 0, 32'h0, 32'h0, 1);
        run("ill_st", 0, 1, 16'h0030, 2'b11, 0, 32'h99999999, 32'h0, 1);
        run("ld_w30", 0, 0, 16'h0030, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0);

        run("st_w40", 0, 1, 16'h0040, 2'b10, 0, 32'hAAAA5555, 32'h0, 0);
        ReqWrite = 1'b1; ReqAddr = 16'h0040; ReqSize = 2'b10; ReqWData = 32'h12345678;
        ReqValid = 1'b1;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk("mid.wait_ready", {31'd0, rdy}, 32'd0);
        Rst = 1'b1;
        #1 chk("mid.rst_ready", {31'd0, rdy}, 32'd0);
        seen = 0;
        repeat (2) begin @(posedge Clk); #1; if (rv) seen++; end
        Rst = 1'b0;
        #1 chk("mid.ready_after", {31'd0, rdy}, 32'd1);
        repeat (5) begin @(posedge Clk); #1; if (rv) seen++; end
        chk("mid.no_resp", seen, 32'd0);
        run("ld_w40", 0, 0, 16'h0040, 2'b10, 0, 32'h0, 32'hAAAA5555, 0);

        ReqWrite = 1'b1; ReqAddr = 16'h0008; ReqSize = 2'b10; ReqSigned = 1'b0;
        ReqWData = 32'h0BADF00D;
        ReqValid0 = 1'b1;
        chk("b2b.ready0", {31'd0, rdy0}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("b2b.ready%0d", k), {31'd0, rdy0}, {31'd0, k % 2 == 0});
            chk($sformatf("b2b.valid%0d", k), {31'd0, rv0}, {31'd0, k % 2 == 1});
        end
        ReqValid0 = 1'b0;
        run("z_ld_w8", 1, 0, 16'h0008, 2'b10, 0, 32'h0, 32'h0BADF00D, 0);
        run("z_st_h", 1, 1, 16'h000A, 2'b01, 0, 32'h00001234, 32'h0, 0);
        run("z_ld_w8b", 1, 0, 16'h0008, 2'b10, 0, 32'h0, 32'h1234F00D, 0);
        run("z_ld_bs", 1, 0, 16'h0009, 2'b00, 1, 32'h0, 32'hFFFFFFF0, 0);
        run("z_mis", 1, 1, 16'h0009, 2'b01, 0, 32'h0000FFFF, 32'h0, 1);
        run("z_ld_w8c", 1, 0, 16'h0008, 2'b10, 0, 32'h0, 32'h1234F00D, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
